// File: rtl/subkey_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// subkey_schedule_ctrl
//
// Sequencer for Threefish-1024 subkey injection. For each subkey s it walks
// the word selector i through 0..15 and supplies the key-word index
// (s+i) mod 17, the tweak index for words 13/14 and the adder control strobe.
// Between injections it launches four mix rounds and waits for them.
//
// Ports:
//   clk            core clock
//   rst_n          asynchronous active-low reset
//   start_i        begin a new block schedule (sampled only in IDLE)
//   abort_i        synchronous abort, back to IDLE from any state
//   word_ready_i   datapath accepts the current word
//   rounds_done_i  round logic finished the 4 rounds after an injection
//   word_valid_o   current word fields valid
//   subkey_num_o   s, current subkey number
//   word_sel_o     i, current word index
//   key_idx_o      (s+i) mod 17
//   tweak_idx_o    s mod 3 on i=13, (s+1) mod 3 on i=14, else 0
//   word_ctrl_o    word_valid_o and i >= 13
//   rounds_start_o one-cycle pulse launching the 4 rounds
//   done_o         one-cycle pulse after the final subkey
//   busy_o         high in any state but IDLE
// ---------------------------------------------------------------------------
module subkey_schedule_ctrl #(
  parameter int NUM_SUBKEYS = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       word_ready_i,
  input  logic       rounds_done_i,
  output logic       word_valid_o,
  output logic [4:0] subkey_num_o,
  output logic [3:0] word_sel_o,
  output logic [4:0] key_idx_o,
  output logic [1:0] tweak_idx_o,
  output logic       word_ctrl_o,
  output logic       rounds_start_o,
  output logic       done_o,
  output logic       busy_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INJECT = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [4:0] LAST_S = 5'(NUM_SUBKEYS - 1);

  // Key-word index counter: 0..16, wraps 16 -> 0.
  function automatic logic [4:0] inc_mod17(input logic [4:0] v);
    if (v >= 5'd16) begin
      return 5'd0;
    end else begin
      return v + 5'd1;
    end
  endfunction

  // Tweak index counter: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    if (v >= 2'd2) begin
      return 2'd0;
    end else begin
      return v + 2'd1;
    end
  endfunction

  logic [1:0] state_r, state_nxt_s;
  logic [4:0] s_r, s_nxt_s;
  logic [3:0] i_r, i_nxt_s;
  logic [4:0] key_base_r, key_base_nxt_s;  // s mod 17
  logic [4:0] key_run_r, key_run_nxt_s;    // (s+i) mod 17
  logic [1:0] tweak_base_r, tweak_base_nxt_s;  // s mod 3
  logic       rounds_start_r, rounds_start_nxt_s;

  logic       in_inject_s;
  logic       index_en_s;

  // Next-state and counter update logic; abort overrides every transition.
  always_comb begin
    state_nxt_s        = state_r;
    s_nxt_s            = s_r;
    i_nxt_s            = i_r;
    key_base_nxt_s     = key_base_r;
    key_run_nxt_s      = key_run_r;
    tweak_base_nxt_s   = tweak_base_r;
    rounds_start_nxt_s = 1'b0;
    if (abort_i) begin
      state_nxt_s      = ST_IDLE;
      s_nxt_s          = 5'd0;
      i_nxt_s          = 4'd0;
      key_base_nxt_s   = 5'd0;
      key_run_nxt_s    = 5'd0;
      tweak_base_nxt_s = 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_nxt_s      = ST_INJECT;
            s_nxt_s          = 5'd0;
            i_nxt_s          = 4'd0;
            key_base_nxt_s   = 5'd0;
            key_run_nxt_s    = 5'd0;
            tweak_base_nxt_s = 2'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_INJECT: begin
          if (word_ready_i) begin
            if (i_r != 4'd15) begin
              i_nxt_s       = i_r + 4'd1;
              key_run_nxt_s = inc_mod17(key_run_r);
            end else if (s_r != LAST_S) begin
              state_nxt_s        = ST_WAIT;
              rounds_start_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ST_DONE;
            end
          end else begin
            state_nxt_s = ST_INJECT;
          end
        end
        ST_WAIT: begin
          if (rounds_done_i) begin
            state_nxt_s      = ST_INJECT;
            s_nxt_s          = s_r + 5'd1;
            i_nxt_s          = 4'd0;
            key_base_nxt_s   = inc_mod17(key_base_r);
            // Word 0 of the next subkey starts at the new base.
            key_run_nxt_s    = inc_mod17(key_base_r);
            tweak_base_nxt_s = inc_mod3(tweak_base_r);
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_DONE: begin
          state_nxt_s      = ST_IDLE;
          s_nxt_s          = 5'd0;
          i_nxt_s          = 4'd0;
          key_base_nxt_s   = 5'd0;
          key_run_nxt_s    = 5'd0;
          tweak_base_nxt_s = 2'd0;
        end
        default: begin
          state_nxt_s      = ST_IDLE;
          s_nxt_s          = 5'd0;
          i_nxt_s          = 4'd0;
          key_base_nxt_s   = 5'd0;
          key_run_nxt_s    = 5'd0;
          tweak_base_nxt_s = 2'd0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      s_r            <= 5'd0;
      i_r            <= 4'd0;
      key_base_r     <= 5'd0;
      key_run_r      <= 5'd0;
      tweak_base_r   <= 2'd0;
      rounds_start_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      s_r            <= s_nxt_s;
      i_r            <= i_nxt_s;
      key_base_r     <= key_base_nxt_s;
      key_run_r      <= key_run_nxt_s;
      tweak_base_r   <= tweak_base_nxt_s;
      rounds_start_r <= rounds_start_nxt_s;
    end
  end

  // Output decode works from registered state only, so word_ready_i never
  // reaches an output combinationally.
  assign in_inject_s = (state_r == ST_INJECT);
  assign index_en_s  = (state_r == ST_INJECT) || (state_r == ST_WAIT);

  assign word_valid_o   = in_inject_s;
  assign subkey_num_o   = index_en_s ? s_r : 5'd0;
  assign word_sel_o     = index_en_s ? i_r : 4'd0;
  assign key_idx_o      = index_en_s ? key_run_r : 5'd0;
  assign word_ctrl_o    = in_inject_s && (i_r >= 4'd13);
  assign rounds_start_o = rounds_start_r;
  assign done_o         = (state_r == ST_DONE);
  assign busy_o         = (state_r != ST_IDLE);

  // Tweak index: base on word 13, base successor on word 14, else 0.
  always_comb begin
    tweak_idx_o = 2'd0;
    if (in_inject_s && (i_r == 4'd13)) begin
      tweak_idx_o = tweak_base_r;
    end else if (in_inject_s && (i_r == 4'd14)) begin
      tweak_idx_o = inc_mod3(tweak_base_r);
    end else begin
      tweak_idx_o = 2'd0;
    end
  end

endmodule

// File: tb/tb_subkey_schedule_ctrl.sv
module tb_subkey_schedule_ctrl;

  localparam int NS = 21;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic       abort_i;
  logic       word_ready_i;
  logic       rounds_done_i;
  logic       word_valid_o;
  logic [4:0] subkey_num_o;
  logic [3:0] word_sel_o;
  logic [4:0] key_idx_o;
  logic [1:0] tweak_idx_o;
  logic       word_ctrl_o;
  logic       rounds_start_o;
  logic       done_o;
  logic       busy_o;

  subkey_schedule_ctrl #(.NUM_SUBKEYS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .word_ready_i(word_ready_i), .rounds_done_i(rounds_done_i),
    .word_valid_o(word_valid_o), .subkey_num_o(subkey_num_o),
    .word_sel_o(word_sel_o), .key_idx_o(key_idx_o), .tweak_idx_o(tweak_idx_o),
    .word_ctrl_o(word_ctrl_o), .rounds_start_o(rounds_start_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int rs_cnt = 0;
  int done_cnt = 0;
  bit bp_mode = 1'b0;
  bit force_rdone = 1'b0;
  logic [16:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] all_outs();
    return {word_valid_o, subkey_num_o, word_sel_o, key_idx_o, tweak_idx_o,
            word_ctrl_o, rounds_start_o, done_o, busy_o};
  endfunction

  // Reference schedule from the arithmetic definition.
  task automatic load_model();
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < 16; i++) begin
        logic [4:0] k;
        logic [1:0] t;
        k = 5'((s + i) % 17);
        t = (i == 13) ? 2'((s) % 3) : (i == 14) ? 2'((s + 1) % 3) : 2'd0;
        exp_q.push_back({5'(s), 4'(i), k, t, (i >= 13) ? 1'b1 : 1'b0});
      end
    end
  endtask

  // Ready driver.
  initial begin
    word_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      word_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Round-logic responder: rounds_done two cycles after rounds_start.
  initial begin
    int cd;
    cd = 0;
    rounds_done_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      rounds_done_i = force_rdone;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) rounds_done_i = 1'b1;
        end
        if (rounds_start_o) cd = 2;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit prev_stall, prev_rs, prev_done;
    logic [16:0] act, prev_act, exp;
    prev_stall = 0; prev_rs = 0; prev_done = 0; prev_act = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0; prev_rs = 0; prev_done = 0;
      end else begin
        act = {subkey_num_o, word_sel_o, key_idx_o, tweak_idx_o, word_ctrl_o};
        if (prev_stall) check("stall_hold", 32'(act), 32'(prev_act));
        if (word_valid_o && word_ready_i) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(act), 32'h1ffff);
          end else begin
            exp = exp_q.pop_front();
            check("word_fields", 32'(act), 32'(exp));
          end
        end
        if (!word_valid_o) check("ctrl_idle", 32'(word_ctrl_o), 32'd0);
        if (rounds_start_o) begin
          rs_cnt++;
          if (prev_rs) check("rs_one_cycle", 32'd1, 32'd0);
        end
        if (done_o) begin
          done_cnt++;
          if (prev_done) check("done_one_cycle", 32'd1, 32'd0);
          check("done_after_all_words", 32'(exp_q.size()), 32'd0);
        end
        prev_stall = word_valid_o && !word_ready_i;
        prev_act   = act;
        prev_rs    = rounds_start_o;
        prev_done  = done_o;
      end
    end
  end

  task automatic start_block(input string tag);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check({tag, "_start_latency"}, 32'({word_valid_o, subkey_num_o, word_sel_o, key_idx_o}),
          32'({1'b1, 5'd0, 4'd0, 5'd0}));
  endtask

  task automatic full_run(input string tag, input bit bp, input bit poke);
    int x0, r0, d0;
    bit p1, p2, seen;
    p1 = 0; p2 = 0; seen = 0;
    bp_mode = bp;
    x0 = xfer_cnt; r0 = rs_cnt; d0 = done_cnt;
    load_model();
    start_block(tag);
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (poke && !p1 && word_valid_o && subkey_num_o == 5'd3 && word_sel_o == 4'd5) begin
        start_i = 1'b1; p1 = 1;
      end else if (poke && !p2 && busy_o && !word_valid_o && !done_o && subkey_num_o == 5'd8) begin
        start_i = 1'b1; p2 = 1;
      end
      if (done_o) seen = 1;
    end
    start_i = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    check({tag, "_busy_drop"}, 32'(busy_o), 32'd0);
    @(negedge clk);
    check({tag, "_xfers"}, 32'(xfer_cnt - x0), 32'd336);
    check({tag, "_rounds_start"}, 32'(rs_cnt - r0), 32'(NS - 1));
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    if (poke) check({tag, "_pokes_applied"}, 32'({p1, p2}), 32'd3);
  endtask

  initial begin
    int r0, d0;
    bit hit;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    #12;
    check("reset_outputs", 32'(all_outs()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", 32'(all_outs()), 32'd0);

    full_run("plain", 1'b0, 1'b0);
    full_run("backpressure", 1'b1, 1'b0);
    full_run("start_busy", 1'b0, 1'b1);

    // Abort at s=7, i=9.
    bp_mode = 1'b0;
    load_model();
    start_block("abort");
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(posedge clk); #1;
      if (word_valid_o && subkey_num_o == 5'd7 && word_sel_o == 4'd9) hit = 1;
    end
    check("abort_point_reached", 32'(hit), 32'd1);
    r0 = rs_cnt; d0 = done_cnt;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    exp_q.delete();
    check("abort_outputs", 32'(all_outs()), 32'd0);
    repeat (4) @(negedge clk);
    check("abort_no_pulses", 32'({rs_cnt - r0, done_cnt - d0}), 32'd0);
    full_run("restart", 1'b0, 1'b0);

    // Asynchronous reset while waiting for rounds at s=10.
    load_model();
    start_block("reset_mid");
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(posedge clk); #1;
      if (busy_o && !word_valid_o && !done_o && subkey_num_o == 5'd10) hit = 1;
    end
    check("wait_s10_reached", 32'(hit), 32'd1);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(all_outs()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    force_rdone = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("rdone_after_reset", 32'(all_outs()), 32'd0);
    end
    force_rdone = 1'b0;
    @(negedge clk);
    check("reset_no_done", 32'(done_cnt - d0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/subkey_schedule_ctrl.md
# subkey_schedule_ctrl

Sequencer for Threefish-1024 subkey injection in the Skein core. For each of the 21 subkeys it steps the subkey word selector through words 0–15 and supplies the state the selector needs:

- key-word index (s+i) mod 17
- tweak index for words 13 and 14
- the control strobe that the word-select demux routes to the word-13/14/15 adders

Between injections it hands off to the round logic and waits for four mix rounds to complete.

## Interface
Parameters:
- NUM_SUBKEYS, default 21: subkeys per block; legal range 2–31.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- start_i  in  1  begin schedule for a new block; sampled only in IDLE
- abort_i  in  1  synchronous abort; returns to IDLE next cycle from any state
- word_ready_i  in  1  selector/datapath accepts current word
- rounds_done_i  in  1  round logic finished the 4 rounds following an injection
- word_valid_o  out  1  current word fields valid
- subkey_num_o  out  5  s, current subkey number
- word_sel_o  out  4  i, current word index 0–15
- key_idx_o  out  5  (s+i) mod 17
- tweak_idx_o  out  2  s mod 3 when i=13; (s+1) mod 3 when i=14; 0 otherwise
- word_ctrl_o  out  1  word_valid_o AND i≥13; feeds demux control input
- rounds_start_o  out  1  one-cycle pulse; launch 4 rounds
- done_o  out  1  one-cycle pulse; final subkey injected
- busy_o  out  1  high in any state but IDLE

## Operation
States: IDLE, INJECT, WAIT_RNDS, DONE.

- **IDLE**
  - start_i=1 → INJECT with s=0, i=0, key base=0, tweak base=0.
  - start_i ignored in every other state.
- **INJECT**
  - word_valid_o=1.
  - Transfer occurs when word_valid_o & word_ready_i; the fields hold while word_ready_i=0.
  - On transfer with i<15: i+1, key_idx+1 with wrap 16→0.
  - On transfer with i=15 and s<NUM_SUBKEYS-1 → WAIT_RNDS; rounds_start_o pulses on the entry cycle.
  - On transfer with i=15 and s=NUM_SUBKEYS-1 → DONE.
- **WAIT_RNDS**
  - word_valid_o=0; s is held.
  - rounds_done_i=1 → INJECT with s+1, i=0.
  - Key base = (base+1) mod 17, i.e. 16→0.
  - Tweak base = (base+1) mod 3.
- **DONE**
  - done_o=1 for one cycle, then IDLE.
- **abort_i** has priority over all transitions:
  - next state IDLE, all counters cleared.
  - No done_o pulse and no rounds_start_o pulse.
- **Arithmetic:** no divide or modulo. key_idx is tracked incrementally as a base register plus a running register. Tweak base is a 0→1→2→0 counter; tweak_idx_o for i=14 is that counter's successor.
- rounds_done_i is ignored outside WAIT_RNDS.
- In IDLE and DONE, all index outputs are 0.

## Timing
- **Reset:** every output is 0 and state is IDLE, applied asynchronously on rst_n low. Release is synchronous to clk.
- All outputs are registered or decoded from registered state only. There is no combinational path from word_ready_i to any output.
- **Start:** start_i high in cycle 0 → word_valid_o=1 with i=0 in cycle 1.
- **Per subkey:** with word_ready_i held high, 16 INJECT cycles.
  - rounds_start_o is asserted in the cycle after word 15 transfers.
  - rounds_done_i in cycle N → next word 0 valid in cycle N+1.
- **Final subkey:** word 15 transfers in cycle M → done_o in cycle M+1 → IDLE in M+2. busy_o drops in M+2.
- **Reset mid-operation:** outputs clear immediately. No pulse completes.

## Test plan
1. **Full run, no stalls.** NUM_SUBKEYS=21; word_ready_i=1; rounds_done_i returned 2 cycles after each rounds_start_o.
   - Expect 336 word transfers, 20 rounds_start_o pulses, one done_o.
   - s=4, i=13 → key_idx_o=0, tweak_idx_o=1.
   - s=4, i=14 → tweak_idx_o=2.
   - s=20, i=0 → key_idx_o=3.
2. **Control strobe.** For every subkey, word_ctrl_o is high exactly on i=13, 14, 15 and nowhere else.
   - s=0, i=15 → key_idx_o=15.
   - s=2, i=15 → key_idx_o=0.
3. **Backpressure.** word_ready_i toggled pseudo-randomly.
   - All fields stay stable while valid & !ready.
   - No word is skipped or duplicated.
   - The transfer sequence is identical to scenario 1.
4. **Start while busy.** start_i pulsed during INJECT of s=3 and during WAIT_RNDS.
   - Both are ignored: no counter disturbance.
   - done_o still arrives after 21 subkeys.
5. **Abort.** abort_i asserted at s=7, i=9.
   - Next cycle: IDLE, busy_o=0, all outputs 0, no done_o.
   - A fresh start_i restarts at s=0, i=0, key_idx_o=0.
6. **Reset mid-run.** rst_n dropped asynchronously in WAIT_RNDS at s=10.
   - Outputs are 0 before the next clk edge.
   - rounds_done_i after release has no effect.
